// File: rtl/pc_seq_pkg.sv
// Shared types and default vectors for the ClassMIPS fetch-stage PC sequencer.
package pc_seq_pkg;

  localparam int          PC_W_DEF      = 32;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_0080;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2
  } pc_state_t;

  typedef enum logic [1:0] {
    SRC_SEQ = 2'd0,
    SRC_BR  = 2'd1,
    SRC_JMP = 2'd2,
    SRC_EXC = 2'd3
  } pc_src_t;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational priority select of the next fetch PC: exception > jump > branch > sequential.
module pc_next_mux
  import pc_seq_pkg::*;
#(
  parameter int              PC_W    = 32,
  parameter logic [PC_W-1:0] EXC_VEC = PC_W'(EXC_VEC_DEF)
) (
  input  logic            redirect_en_i,
  input  logic            exception_i,
  input  logic            jump_i,
  input  logic            branch_taken_i,
  input  logic            accept_i,
  input  logic [PC_W-1:0] fetch_pc_i,
  input  logic [PC_W-1:0] pc_i,
  input  logic [PC_W-1:0] jump_target_i,
  input  logic [PC_W-1:0] branch_offset_i,
  output logic [PC_W-1:0] next_pc_o,
  output pc_src_t         src_o
);

  localparam logic [PC_W-1:0] ONE = {{(PC_W-1){1'b0}}, 1'b1};

  always_comb begin
    next_pc_o = fetch_pc_i;
    src_o     = SRC_SEQ;
    if (redirect_en_i && exception_i) begin
      next_pc_o = EXC_VEC;
      src_o     = SRC_EXC;
    end else if (redirect_en_i && jump_i) begin
      next_pc_o = jump_target_i;
      src_o     = SRC_JMP;
    end else if (redirect_en_i && branch_taken_i) begin
      // Offset is two's complement, so plain modular addition sign-extends it.
      next_pc_o = pc_i + ONE + branch_offset_i;
      src_o     = SRC_BR;
    end else if (accept_i) begin
      next_pc_o = fetch_pc_i + ONE;
      src_o     = SRC_SEQ;
    end else begin
      next_pc_o = fetch_pc_i;
      src_o     = SRC_SEQ;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: owns fetch_pc, drives the imem request handshake and
// hands accepted addresses to decode, applying stalls and branch/jump/exception redirects.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(RESET_VEC_DEF),
  parameter logic [PC_W-1:0] EXC_VEC   = PC_W'(EXC_VEC_DEF)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            branch_taken_i,
  input  logic [PC_W-1:0] branch_offset_i,
  input  logic            jump_i,
  input  logic [PC_W-1:0] jump_target_i,
  input  logic            exception_i,
  output logic            imem_req_o,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic            imem_ready_i,
  output logic [PC_W-1:0] pc_o,
  output logic            pc_valid_o,
  output logic            flush_o,
  output logic [PC_W-1:0] epc_o
);

  pc_state_t       state_q;
  logic [PC_W-1:0] fetch_pc_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] epc_q;
  logic            pc_valid_q;
  logic            flush_q;

  logic            redirect;
  logic            accept;
  logic [PC_W-1:0] next_pc_d;
  pc_src_t         src_d;

  // Redirects are only honoured against a valid instruction in decode.
  assign redirect   = pc_valid_q & (exception_i | jump_i | branch_taken_i);
  assign imem_req_o = (state_q == FETCH) & (redirect | ~stall_i);
  assign accept     = imem_req_o & imem_ready_i;

  pc_next_mux #(
    .PC_W    (PC_W),
    .EXC_VEC (EXC_VEC)
  ) u_next_mux (
    .redirect_en_i   (pc_valid_q),
    .exception_i     (exception_i),
    .jump_i          (jump_i),
    .branch_taken_i  (branch_taken_i),
    .accept_i        (accept),
    .fetch_pc_i      (fetch_pc_q),
    .pc_i            (pc_q),
    .jump_target_i   (jump_target_i),
    .branch_offset_i (branch_offset_i),
    .next_pc_o       (next_pc_d),
    .src_o           (src_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_VEC;
      pc_q       <= '0;
      pc_valid_q <= 1'b0;
      flush_q    <= 1'b0;
      epc_q      <= '0;
    end else begin
      flush_q <= 1'b0;
      case (state_q)
        BOOT: begin
          state_q <= FETCH;
        end
        FETCH, STALL: begin
          if (redirect) begin
            // Any same-cycle accept is dropped: the response belongs to the squashed path.
            fetch_pc_q <= next_pc_d;
            pc_valid_q <= 1'b0;
            flush_q    <= 1'b1;
            state_q    <= FETCH;
            if (src_d == SRC_EXC) begin
              epc_q <= pc_q;
            end
          end else if (stall_i) begin
            state_q <= STALL;
          end else if (state_q == STALL) begin
            state_q <= FETCH;
          end else begin
            fetch_pc_q <= next_pc_d;
            pc_valid_q <= accept;
            if (accept) begin
              pc_q <= fetch_pc_q;
            end
          end
        end
        default: begin
          state_q <= BOOT;
        end
      endcase
    end
  end

  assign imem_addr_o = fetch_pc_q;
  assign pc_o        = pc_q;
  assign pc_valid_o  = pc_valid_q;
  assign flush_o     = flush_q;
  assign epc_o       = epc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, async reset check,
// then randomized stimulus against a behavioural fetch model.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        stall_i;
  logic        branch_taken_i;
  logic [31:0] branch_offset_i;
  logic        jump_i;
  logic [31:0] jump_target_i;
  logic        exception_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic [31:0] pc_o;
  logic        pc_valid_o;
  logic        flush_o;
  logic [31:0] epc_o;

  int errors = 0;
  int checks = 0;

  pc_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_offset_i (branch_offset_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .exception_i     (exception_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_ready_i    (imem_ready_i),
    .pc_o            (pc_o),
    .pc_valid_o      (pc_valid_o),
    .flush_o         (flush_o),
    .epc_o           (epc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic        br;
    logic [31:0] off;
    logic        jmp;
    logic [31:0] tgt;
    logic        exc;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic        e_val;
    logic        e_fl;
    logic [31:0] e_epc;
  } vec_t;

  vec_t vec[$];

  // Behavioural model: what decode/memory should observe, tracked as plain flags and counters.
  bit          m_boot;
  bit          m_stall;
  bit          m_val;
  bit          m_fl;
  logic [31:0] m_fpc;
  logic [31:0] m_pc;
  logic [31:0] m_epc;

  function automatic vec_t mk(input logic st, input logic br, input logic [31:0] off,
                              input logic jp, input logic [31:0] tg, input logic ex,
                              input logic rdy, input logic e_req, input logic [31:0] e_addr,
                              input logic [31:0] e_pc, input logic e_val, input logic e_fl,
                              input logic [31:0] e_epc);
    vec_t v;
    v.stall = st; v.br = br; v.off = off; v.jmp = jp; v.tgt = tg; v.exc = ex; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_pc = e_pc; v.e_val = e_val; v.e_fl = e_fl;
    v.e_epc = e_epc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic st, input logic br, input logic [31:0] off,
                       input logic jp, input logic [31:0] tg, input logic ex, input logic rdy);
    stall_i = st; branch_taken_i = br; branch_offset_i = off;
    jump_i = jp; jump_target_i = tg; exception_i = ex; imem_ready_i = rdy;
  endtask

  task automatic model_reset();
    m_boot = 1'b1; m_stall = 1'b0; m_val = 1'b0; m_fl = 1'b0;
    m_fpc = 32'h0; m_pc = 32'h0; m_epc = 32'h0;
  endtask

  function automatic bit model_redirect();
    return m_val && (exception_i || jump_i || branch_taken_i);
  endfunction

  function automatic bit model_req();
    return !m_boot && !m_stall && (model_redirect() || !stall_i);
  endfunction

  task automatic model_step();
    bit redir;
    bit acc;
    redir = model_redirect();
    acc   = model_req() && imem_ready_i;
    if (m_boot) begin
      m_boot = 1'b0;
      m_fl   = 1'b0;
    end else if (redir) begin
      m_fl = 1'b1; m_val = 1'b0; m_stall = 1'b0;
      if (exception_i) begin
        m_epc = m_pc;
        m_fpc = 32'h80;
      end else if (jump_i) begin
        m_fpc = jump_target_i;
      end else begin
        m_fpc = m_pc + 32'd1 + branch_offset_i;
      end
    end else begin
      m_fl = 1'b0;
      if (stall_i) begin
        m_stall = 1'b1;
      end else if (m_stall) begin
        m_stall = 1'b0;
      end else begin
        m_val = acc;
        if (acc) begin
          m_pc  = m_fpc;
          m_fpc = m_fpc + 32'd1;
        end
      end
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req",   {31'b0, imem_req_o}, 32'h0);
    chk("rst_addr",  imem_addr_o,         32'h0);
    chk("rst_valid", {31'b0, pc_valid_o}, 32'h0);
    chk("rst_flush", {31'b0, flush_o},    32'h0);
    chk("rst_epc",   epc_o,               32'h0);

    //               st   br   off            jp   tgt            ex   rdy | req addr           pc             val  fl   epc
    vec.push_back(mk(1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b1, 1'b0,32'h0,        32'h0,        1'b0,1'b0,32'h0));
    vec.push_back(mk(1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b1, 1'b1,32'h0,        32'h0,        1'b0,1'b0,32'h0));
    vec.push_back(mk(1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b1, 1'b1,32'h1,        32'h0,        1'b1,1'b0,32'h0));
    vec.push_back(mk(1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b1, 1'b1,32'h2,        32'h1,        1'b1,1'b0,32'h0));
    vec.push_back(mk(1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0, 1'b1,32'h3,        32'h2,        1'b1,1'b0,32'h0));
    vec.push_back(mk(1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b1, 1'b1,32'h3,        32'h2,        1'b0,1'b0,32'h0));
    vec.push_back(mk(1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b1, 1'b0,32'h4,        32'h3,        1'b1,1'b0,32'h0));
    vec.push_back(mk(1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b1, 1'b0,32'h4,        32'h3,        1'b1,1'b0,32'h0));
    vec.push_back(mk(1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b1, 1'b0,32'h4,        32'h3,        1'b1,1'b0,32'h0));
    vec.push_back(mk(1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b1, 1'b1,32'h4,        32'h3,        1'b1,1'b0,32'h0));
    vec.push_back(mk(1'b0,1'b1,32'hFFFFFFFD, 1'b0,32'h0,        1'b0,1'b1, 1'b1,32'h5,        32'h4,        1'b1,1'b0,32'h0));
    vec.push_back(mk(1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b1, 1'b1,32'h2,        32'h4,        1'b0,1'b1,32'h0));
    vec.push_back(mk(1'b0,1'b0,32'h0,        1'b1,32'h40,       1'b1,1'b1, 1'b1,32'h3,        32'h2,        1'b1,1'b0,32'h0));
    vec.push_back(mk(1'b0,1'b0,32'h0,        1'b1,32'h55,       1'b0,1'b1, 1'b1,32'h80,       32'h2,        1'b0,1'b1,32'h2));
    vec.push_back(mk(1'b0,1'b0,32'h0,        1'b1,32'hFFFFFFFF, 1'b0,1'b1, 1'b1,32'h81,       32'h80,       1'b1,1'b0,32'h2));
    vec.push_back(mk(1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b1, 1'b1,32'hFFFFFFFF, 32'h80,       1'b0,1'b1,32'h2));
    vec.push_back(mk(1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b1, 1'b1,32'h0,        32'hFFFFFFFF, 1'b1,1'b0,32'h2));
    vec.push_back(mk(1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b1, 1'b0,32'h1,        32'h0,        1'b1,1'b0,32'h2));
    vec.push_back(mk(1'b1,1'b0,32'h0,        1'b1,32'h10,       1'b0,1'b1, 1'b0,32'h1,        32'h0,        1'b1,1'b0,32'h2));
    vec.push_back(mk(1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b1, 1'b0,32'h10,       32'h0,        1'b0,1'b1,32'h2));
    vec.push_back(mk(1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b1, 1'b0,32'h10,       32'h0,        1'b0,1'b0,32'h2));
    vec.push_back(mk(1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b1, 1'b1,32'h10,       32'h0,        1'b0,1'b0,32'h2));
    vec.push_back(mk(1'b1,1'b1,32'h0,        1'b0,32'h0,        1'b0,1'b1, 1'b1,32'h11,       32'h10,       1'b1,1'b0,32'h2));
    vec.push_back(mk(1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0, 1'b1,32'h11,       32'h10,       1'b0,1'b1,32'h2));

    reset = 1'b1;
    for (int i = 0; i < vec.size(); i++) begin
      drive(vec[i].stall, vec[i].br, vec[i].off, vec[i].jmp, vec[i].tgt, vec[i].exc, vec[i].rdy);
      #1;
      chk($sformatf("v%0d_req", i),   {31'b0, imem_req_o}, {31'b0, vec[i].e_req});
      chk($sformatf("v%0d_addr", i),  imem_addr_o,         vec[i].e_addr);
      chk($sformatf("v%0d_pc", i),    pc_o,                vec[i].e_pc);
      chk($sformatf("v%0d_valid", i), {31'b0, pc_valid_o}, {31'b0, vec[i].e_val});
      chk($sformatf("v%0d_flush", i), {31'b0, flush_o},    {31'b0, vec[i].e_fl});
      chk($sformatf("v%0d_epc", i),   epc_o,               vec[i].e_epc);
      @(negedge clk);
    end

    // Mid-operation reset must clear outputs without waiting for a clock edge.
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_req",   {31'b0, imem_req_o}, 32'h0);
    chk("async_addr",  imem_addr_o,         32'h0);
    chk("async_pc",    pc_o,                32'h0);
    chk("async_valid", {31'b0, pc_valid_o}, 32'h0);
    chk("async_flush", {31'b0, flush_o},    32'h0);
    chk("async_epc",   epc_o,               32'h0);

    @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      logic [31:0] off;
      logic [31:0] tgt;
      off = ($urandom_range(0, 3) == 0) ? 32'($urandom) : (32'($urandom_range(0, 31)) - 32'd16);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFF - 32'($urandom_range(0, 3)))
                                        : 32'($urandom_range(0, 255));
      drive($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, off,
            $urandom_range(0, 19) == 0, tgt, $urandom_range(0, 29) == 0,
            $urandom_range(0, 3) != 0);
      #1;
      chk("rnd_req",   {31'b0, imem_req_o}, {31'b0, model_req()});
      chk("rnd_addr",  imem_addr_o,         m_fpc);
      chk("rnd_pc",    pc_o,                m_pc);
      chk("rnd_valid", {31'b0, pc_valid_o}, {31'b0, m_val});
      chk("rnd_flush", {31'b0, flush_o},    {31'b0, m_fl});
      chk("rnd_epc",   epc_o,               m_epc);
      model_step();
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
